// File: rtl/ad7768_spi_pkg.sv
// Shared constants and types for the SPI register slave: frame layout, FSM encoding, revision ID.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ad7768_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_t;

    localparam int          FRAME_W     = 16;
    localparam int          RW_BIT      = 15;   // 1 = read, 0 = write
    localparam int          ADDR_HI     = 14;
    localparam int          ADDR_LO     = 8;
    localparam logic [6:0]  REV_ID_ADDR = 7'h0A;
    localparam logic [7:0]  REV_ID_VAL  = 8'h06;

    // Response word: {R/W, addr} echoed in the top byte, data byte below.
    function automatic logic [15:0] make_resp(input logic rw, input logic [6:0] addr,
                                              input logic [7:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for one asynchronous input plus rise/fall pulse detection on the synced level.
// Latency: STAGES clk from input change to q; rise/fall pulse in the same cycle q changes.
// Backpressure: none; free-running every clk.
// Ports: clk/rst_n system clock and async reset; din raw input; q synced level;
//        rise/fall one-clk pulses on synced edges.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= (chain << 1) | STAGES'(din);
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: 16-bit frames {R/W, addr[6:0], data[7:0]} over an oversampled clk domain.
// Latency: commit one clk after synced cs_n rise; read data returned on sdo during the following frame.
// Backpressure: none; the SPI master paces all transfers, clk must be >= 8x sck.
// Ports: clk/rst_n system clock and async active-low reset; sck/cs_n/sdi raw SPI inputs; sdo SPI output;
//        frame_done/frame_err one-clk frame status pulses; wr_stb/wr_addr/wr_data committed-write report.
module spi_reg_slave
    import ad7768_spi_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       sdi,
    output logic       sdo,
    output logic       frame_done,
    output logic       frame_err,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data
);

    logic sck_lvl_unused, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic sdi_q, sdi_rise_unused, sdi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(sck),
        .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .din(sdi),
        .q(sdi_q), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

    spi_state_t        state, state_nxt;
    logic [15:0]       rx_sr;
    logic [4:0]        bit_cnt;
    logic [15:0]       resp;
    logic [15:0]       tx_sr;
    logic [7:0]        regs [NUM_REGS];

    // The cs_n synchronizer resets to 'deselected', so releasing reset while the
    // master holds cs_n low looks like a falling edge. Frames are only accepted
    // once the chain has been flushed and cs_n has actually been seen high.
    logic [SYNC_STAGES-1:0] flush;
    logic                   armed;

    logic        start_frame, frame_ok, wr_en, addr_ok, rw;
    logic [6:0]  addr;
    logic [7:0]  data, rd_data;
    logic [15:0] resp_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cs_fall && armed) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (cs_rise)          state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = cs_fall ? ST_SHIFT : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rw       = rx_sr[RW_BIT];
        addr     = rx_sr[ADDR_HI:ADDR_LO];
        data     = rx_sr[7:0];
        addr_ok  = int'(addr) < NUM_REGS;
        rd_data  = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ok && addr == i[6:0]) rd_data = regs[i];
        end
        start_frame = cs_fall && ((state == ST_IDLE && armed) || state == ST_COMMIT);
        frame_ok    = (state == ST_COMMIT) && (bit_cnt == 5'(FRAME_W));
        wr_en       = frame_ok && !rw && addr_ok && (addr != REV_ID_ADDR);
        resp_nxt    = make_resp(rw, addr, rw ? rd_data : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush      <= '0;
            armed      <= 1'b0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            resp       <= '0;
            tx_sr      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            wr_stb     <= 1'b0;
            flush      <= (flush << 1) | SYNC_STAGES'(1);
            if (!armed && flush[SYNC_STAGES-1] && cs_q) armed <= 1'b1;

            // Edges past the 16th are dropped so over-long frames decode as 16 bits.
            if (start_frame) begin
                rx_sr   <= '0;
                bit_cnt <= '0;
            end else if (state == ST_SHIFT && sck_rise && !cs_q && bit_cnt < 5'(FRAME_W)) begin
                rx_sr   <= {rx_sr[14:0], sdi_q};
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (state == ST_COMMIT) begin
                if (frame_ok) begin
                    frame_done <= 1'b1;
                    resp       <= resp_nxt;
                    if (wr_en) begin
                        wr_stb  <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= data;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end

            // Back-to-back frames start in COMMIT, where resp is still being written.
            if (start_frame)
                tx_sr <= frame_ok ? resp_nxt : resp;
            else if (state == ST_SHIFT && sck_fall && !cs_q)
                tx_sr <= tx_sr << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i[6:0] == REV_ID_ADDR) ? REV_ID_VAL : 8'h00;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (addr == i[6:0]) regs[i] <= data;
        end
    end

    assign sdo = tx_sr[15] & ~cs_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
module tb_spi_reg_slave;

    localparam int HALF = 80;   // sck half period (ns); clk period 10 ns -> 16x oversampling

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo, frame_done, frame_err, wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_err = 0, n_stb = 0;

    always #5 clk = ~clk;

    spi_reg_slave dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
        .frame_done(frame_done), .frame_err(frame_err), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data));

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if (wr_stb)     n_stb++;
    end

    typedef struct {
        logic [15:0] mosi;
        int          nbits;
        logic [31:0] miso;   // sdo bits collected during this frame, right-aligned
        int          done;
        int          err;
        int          stb;
        logic [6:0]  waddr;
        logic [7:0]  wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic spi_frame(input logic [15:0] mosi, input int nbits,
                             output logic [31:0] miso, output logic early);
        miso = '0;
        @(negedge clk);
        cs_n = 1'b0;
        sdi  = mosi[15];
        repeat (3) @(posedge clk);   // SYNC_STAGES+1 clk after cs_n fall
        #1 early = sdo;
        #(HALF - 26);
        for (int i = 0; i < nbits; i++) begin
            miso = {miso[30:0], sdo};
            sck  = 1'b1;
            #HALF;
            sck  = 1'b0;
            sdi  = (i + 1 < 16) ? mosi[14 - i] : 1'b0;
            #HALF;
        end
        cs_n = 1'b1;
        sdi  = 1'b0;
        #300;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          d0, e0, s0;
        logic [31:0] miso;
        logic        early;
        d0 = n_done; e0 = n_err; s0 = n_stb;
        spi_frame(v.mosi, v.nbits, miso, early);
        chk({tag, " sdo_frame"}, miso, v.miso);
        chk({tag, " sdo_first_bit"}, 32'(early), 32'(v.miso[v.nbits - 1]));
        chk({tag, " frame_done"}, 32'(n_done - d0), 32'(v.done));
        chk({tag, " frame_err"}, 32'(n_err - e0), 32'(v.err));
        chk({tag, " wr_stb"}, 32'(n_stb - s0), 32'(v.stb));
        if (v.stb != 0) begin
            chk({tag, " wr_addr"}, 32'(wr_addr), 32'(v.waddr));
            chk({tag, " wr_data"}, 32'(wr_data), 32'(v.wdata));
        end
    endtask

    vec_t main_vecs [12];
    vec_t post_vecs [3];

    initial begin
        //                  mosi     bits miso        done err stb waddr  wdata
        main_vecs[0]  = '{16'h03A5, 16, 32'h0000_0000, 1, 0, 1, 7'h03, 8'hA5}; // write 3=A5
        main_vecs[1]  = '{16'h8300, 16, 32'h0000_0300, 1, 0, 0, 7'h00, 8'h00}; // read 3
        main_vecs[2]  = '{16'h8A00, 16, 32'h0000_83A5, 1, 0, 0, 7'h00, 8'h00}; // read rev
        main_vecs[3]  = '{16'h0AFF, 16, 32'h0000_8A06, 1, 0, 0, 7'h00, 8'h00}; // write RO
        main_vecs[4]  = '{16'h8A00, 16, 32'h0000_0A00, 1, 0, 0, 7'h00, 8'h00}; // read rev
        main_vecs[5]  = '{16'h8300,  9, 32'h0000_0114, 0, 1, 0, 7'h00, 8'h00}; // abort 9b
        main_vecs[6]  = '{16'h8300, 16, 32'h0000_8A06, 1, 0, 0, 7'h00, 8'h00}; // read 3
        main_vecs[7]  = '{16'hC000, 16, 32'h0000_83A5, 1, 0, 0, 7'h00, 8'h00}; // read 0x40
        main_vecs[8]  = '{16'h053C, 20, 32'h000C_0000, 1, 0, 1, 7'h05, 8'h3C}; // 20 edges
        main_vecs[9]  = '{16'h8500, 16, 32'h0000_0500, 1, 0, 0, 7'h00, 8'h00}; // read 5
        main_vecs[10] = '{16'h2011, 16, 32'h0000_853C, 1, 0, 0, 7'h00, 8'h00}; // write 0x20
        main_vecs[11] = '{16'h8000, 16, 32'h0000_2000, 1, 0, 0, 7'h00, 8'h00}; // read 0

        post_vecs[0]  = '{16'h075A, 16, 32'h0000_0000, 1, 0, 1, 7'h07, 8'h5A}; // write 7=5A
        post_vecs[1]  = '{16'h8A00, 16, 32'h0000_0700, 1, 0, 0, 7'h00, 8'h00}; // read rev
        post_vecs[2]  = '{16'h8300, 16, 32'h0000_8A06, 1, 0, 0, 7'h00, 8'h00}; // read 3 (reset)

        // Reset state
        #23;
        chk("reset outputs", {16'h0, sdo, frame_done, frame_err, wr_stb, wr_addr, wr_data}, 32'h0);
        rst_n = 1'b1;
        #200;
        chk("idle sdo", 32'(sdo), 32'h0);

        for (int i = 0; i < 12; i++)
            run_vec($sformatf("main%0d", i), main_vecs[i]);

        // Reset asserted mid-frame after 8 bits, released while cs_n is still low
        begin
            int d0, e0, s0;
            logic [15:0] m;
            m = 16'h03A5;
            @(negedge clk);
            cs_n = 1'b0;
            #HALF;
            for (int i = 0; i < 8; i++) begin
                sdi = m[15 - i];
                #HALF; sck = 1'b1; #HALF; sck = 1'b0;
            end
            rst_n = 1'b0;
            #1;
            chk("midreset outputs", {16'h0, sdo, frame_done, frame_err, wr_stb, wr_addr, wr_data}, 32'h0);
            #50;
            rst_n = 1'b1;
            d0 = n_done; e0 = n_err; s0 = n_stb;
            for (int i = 8; i < 16; i++) begin
                sdi = m[15 - i];
                #HALF; sck = 1'b1; #HALF; sck = 1'b0;
            end
            #HALF;
            cs_n = 1'b1;
            sdi  = 1'b0;
            #300;
            chk("midreset no done", 32'(n_done - d0), 32'h0);
            chk("midreset no err", 32'(n_err - e0), 32'h0);
            chk("midreset no stb", 32'(n_stb - s0), 32'h0);
            chk("midreset wr_addr", 32'(wr_addr), 32'h0);
            chk("midreset sdo idle", 32'(sdo), 32'h0);
        end

        for (int i = 0; i < 3; i++)
            run_vec($sformatf("post%0d", i), post_vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
